// File: rtl/dma_apb_regs.sv
// APB3 register file and start/completion sequencer in front of the DMA engine.
// Holds the transfer configuration, pulses the start mode and keeps sticky done/result status.
module dma_apb_regs #(
    parameter int REG_DATA_WIDTH = 32,
    parameter int APB_ADDR_WIDTH = 8,
    parameter int MODE           = 2,
    parameter int APB_WAIT       = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [APB_ADDR_WIDTH-1:0] paddr,
    input  logic [REG_DATA_WIDTH-1:0] pwdata,
    output logic [REG_DATA_WIDTH-1:0] prdata,
    output logic                      pready,
    output logic                      pslverr,
    output logic [REG_DATA_WIDTH-1:0] out_src_addr,
    output logic [REG_DATA_WIDTH-1:0] out_dest_addr,
    output logic [REG_DATA_WIDTH-1:0] out_transfer_size,
    output logic [MODE-1:0]           out_mode,
    input  logic                      in_done,
    input  logic [1:0]                in_success,
    output logic                      out_irq
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    localparam logic [APB_ADDR_WIDTH-1:0] A_SRC    = APB_ADDR_WIDTH'(8'h00);
    localparam logic [APB_ADDR_WIDTH-1:0] A_DEST   = APB_ADDR_WIDTH'(8'h04);
    localparam logic [APB_ADDR_WIDTH-1:0] A_SIZE   = APB_ADDR_WIDTH'(8'h08);
    localparam logic [APB_ADDR_WIDTH-1:0] A_CTRL   = APB_ADDR_WIDTH'(8'h0C);
    localparam logic [APB_ADDR_WIDTH-1:0] A_STATUS = APB_ADDR_WIDTH'(8'h10);
    localparam logic [APB_ADDR_WIDTH-1:0] A_IRQEN  = APB_ADDR_WIDTH'(8'h14);

    state_t                    state;
    logic [2:0]                wait_cnt;
    logic [REG_DATA_WIDTH-1:0] src, dest, size;
    logic [MODE-1:0]           ctrl_mode, mode_pulse;
    logic                      busy, done, irq_en;
    logic [1:0]                result;

    logic                      mapped, cfg_reg, mode_ok, err, commit, wr_ok;
    logic [MODE-1:0]           wmode;
    logic [REG_DATA_WIDTH-1:0] rdata;

    always_comb begin
        mapped  = 1'b0;
        cfg_reg = 1'b0;
        rdata   = '0;
        case (paddr)
            A_SRC:    begin mapped = 1'b1; cfg_reg = 1'b1; rdata = src;  end
            A_DEST:   begin mapped = 1'b1; cfg_reg = 1'b1; rdata = dest; end
            A_SIZE:   begin mapped = 1'b1; cfg_reg = 1'b1; rdata = size; end
            A_CTRL:   begin mapped = 1'b1; cfg_reg = 1'b1; rdata = REG_DATA_WIDTH'(ctrl_mode); end
            A_STATUS: begin mapped = 1'b1; rdata = REG_DATA_WIDTH'({result, done, busy}); end
            A_IRQEN:  begin mapped = 1'b1; rdata = REG_DATA_WIDTH'(irq_en); end
            default:  ;
        endcase
        wmode   = pwdata[MODE-1:0];
        mode_ok = (wmode == MODE'(1)) || (wmode == MODE'(2));
        // Config may not change under a running transfer; a start needs a legal mode and a non-zero size.
        err = !mapped
            || (pwrite && busy && cfg_reg)
            || (pwrite && (paddr == A_CTRL) && (!mode_ok || (size == '0)));
    end

    assign pready  = (state == ACCESS) && (wait_cnt == 3'(APB_WAIT));
    assign pslverr = pready && err;
    assign prdata  = (pready && !err) ? rdata : '0;
    assign commit  = pready && psel;
    assign wr_ok   = commit && pwrite && !err;

    assign out_src_addr      = src;
    assign out_dest_addr     = dest;
    assign out_transfer_size = size;
    assign out_mode          = mode_pulse;
    assign out_irq           = done && irq_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            src        <= '0;
            dest       <= '0;
            size       <= '0;
            ctrl_mode  <= '0;
            mode_pulse <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            irq_en     <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (psel && !penable) state <= SETUP;
                SETUP: begin
                    if (!psel) state <= IDLE;
                    else if (penable) begin
                        state    <= ACCESS;
                        wait_cnt <= '0;
                    end
                end
                ACCESS: begin
                    if (!psel) state <= IDLE;
                    else if (pready) state <= penable ? IDLE : SETUP;
                    else wait_cnt <= wait_cnt + 3'd1;
                end
                default: state <= IDLE;
            endcase

            mode_pulse <= '0;
            if (wr_ok) begin
                case (paddr)
                    A_SRC:  src  <= pwdata;
                    A_DEST: dest <= pwdata;
                    A_SIZE: size <= pwdata;
                    A_CTRL: begin
                        ctrl_mode  <= wmode;
                        mode_pulse <= wmode;
                        busy       <= 1'b1;
                    end
                    A_STATUS: if (pwdata[1]) begin
                        done   <= 1'b0;
                        result <= '0;
                    end
                    A_IRQEN: irq_en <= pwdata[0];
                    default: ;
                endcase
            end

            // Placed after the W1C so a coincident completion leaves done set.
            if (in_done && busy) begin
                busy   <= 1'b0;
                done   <= 1'b1;
                result <= in_success;
            end
        end
    end
endmodule
